lamp_safety_monitor: RTL and testbench



---
 rtl/lamp_mon_pkg.sv | 34 +++
 rtl/lamp_head_check.sv | 79 +++++++
 rtl/lamp_safety_monitor.sv | 187 ++++++++++++++++++
 tb/tb_lamp_safety_monitor.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lamp_mon_pkg.sv
// Shared types and constants for the lamp safety monitor.
//   state_t : monitor FSM states (all-red hold, pass-through, fault flash)
//   head_t  : one signal head {g, y, r}
//   codes   : fault codes; the lowest non-zero code has the highest priority
//   cnt_w   : width of a saturating counter that must reach n
package lamp_mon_pkg;

  localparam int unsigned CODE_W = 3;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_RUN    = 2'd1,
    ST_FLASH  = 2'd2
  } state_t;

  localparam logic [CODE_W-1:0] NONE      = 3'd0;
  localparam logic [CODE_W-1:0] CONFLICT  = 3'd1;
  localparam logic [CODE_W-1:0] MULTI     = 3'd2;
  localparam logic [CODE_W-1:0] DARK      = 3'd3;
  localparam logic [CODE_W-1:0] SHORT_YLW = 3'd4;
  localparam logic [CODE_W-1:0] SKIP_YLW  = 3'd5;

  typedef struct packed {
    logic g;
    logic y;
    logic r;
  } head_t;

  // Never returns zero, so a parameter of 0 still yields a legal vector width.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lamp_head_check.sv
// Per-head sequence checker. Keeps the previous sample (S1p), the
// consecutive-yellow count and the consecutive-dark count for one head and
// reports the highest-priority head-local violation of the current sample.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : high while the monitor is passing lamps through; when low,
//                S1p and both counters are held at zero so checking restarts
//                from a clean history on the next entry to pass-through
//   s1         : current registered sample of this head
//   code_c     : MULTI, DARK, SHORT_YLW, SKIP_YLW or NONE (combinational)
module lamp_head_check
  import lamp_mon_pkg::*;
#(
  parameter int unsigned MIN_YLW  = 3,
  parameter int unsigned MAX_DARK = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  head_t             s1,
  output logic [CODE_W-1:0] code_c
);

  localparam int unsigned YW = cnt_w(MIN_YLW);
  localparam int unsigned DW = cnt_w(MAX_DARK);

  head_t         s1p;
  logic [YW-1:0] ylw_cnt;
  logic [DW-1:0] dark_cnt;

  logic multi_c;
  logic dark_c;

  assign multi_c = (s1.g & s1.y) | (s1.g & s1.r) | (s1.y & s1.r);
  assign dark_c  = ~(s1.g | s1.y | s1.r);

  // Violation decode; dark_cnt holds the dark run ending at S1p, so the
  // current dark cycle makes it dark_cnt+1 long.
  always_comb begin
    code_c = NONE;
    if (en) begin
      if (multi_c) begin
        code_c = MULTI;
      end else if (dark_c && (dark_cnt >= DW'(MAX_DARK))) begin
        code_c = DARK;
      end else if (s1p.y && !s1.y && (ylw_cnt < YW'(MIN_YLW))) begin
        code_c = SHORT_YLW;
      end else if (s1p.g && s1.r && !s1.g) begin
        code_c = SKIP_YLW;
      end
    end
  end

  // History registers; counters saturate so they never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1p      <= '0;
      ylw_cnt  <= '0;
      dark_cnt <= '0;
    end else if (!en) begin
      s1p      <= '0;
      ylw_cnt  <= '0;
      dark_cnt <= '0;
    end else begin
      s1p <= s1;
      if (!s1.y) begin
        ylw_cnt <= '0;
      end else if (ylw_cnt < YW'(MIN_YLW)) begin
        ylw_cnt <= ylw_cnt + 1'b1;
      end
      if (!dark_c) begin
        dark_cnt <= '0;
      end else if (dark_cnt < DW'(MAX_DARK)) begin
        dark_cnt <= dark_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lamp_safety_monitor.sv
// Lamp conflict monitor between the traffic-light sequencer and the lamp
// drivers. Samples the six lamp requests, checks every sample, and either
// passes it to the drivers or falls back to flashing red with a latched fault.
// Ports:
//   CK, CLR            : clock (rising edge), async active-low reset
//   GRN1..RED2         : lamp requests from the sequencer
//   ACK                : operator acknowledge, honoured only while flashing
//   L_GRN1..L_RED2     : registered lamp drives
//   FAULT              : fault latched, not yet acknowledged
//   FAULT_CODE         : first fault code seen, 0 when none
//   FLASH              : monitor is in the flashing-red state
module lamp_safety_monitor
  import lamp_mon_pkg::*;
#(
  parameter int unsigned MIN_YLW    = 3,
  parameter int unsigned MAX_DARK   = 1,
  parameter int unsigned FLASH_HALF = 4,
  parameter int unsigned ALLRED_CYC = 8
) (
  input  logic              CK,
  input  logic              CLR,
  input  logic              GRN1,
  input  logic              YLW1,
  input  logic              RED1,
  input  logic              GRN2,
  input  logic              YLW2,
  input  logic              RED2,
  input  logic              ACK,
  output logic              L_GRN1,
  output logic              L_YLW1,
  output logic              L_RED1,
  output logic              L_GRN2,
  output logic              L_YLW2,
  output logic              L_RED2,
  output logic              FAULT,
  output logic [CODE_W-1:0] FAULT_CODE,
  output logic              FLASH
);

  localparam int unsigned AW = cnt_w(ALLRED_CYC);
  localparam int unsigned FW = cnt_w(FLASH_HALF);

  localparam head_t RED_ON  = head_t'(3'b001);
  localparam head_t ALL_OFF = head_t'(3'b000);

  head_t         s1_h1;
  head_t         s1_h2;
  head_t         drv_h1;
  head_t         drv_h2;
  state_t        state;
  logic [AW-1:0] ar_cnt;
  logic [FW-1:0] fl_cnt;

  logic              run_c;
  logic              conflict_c;
  logic [CODE_W-1:0] code_h1_c;
  logic [CODE_W-1:0] code_h2_c;
  logic [CODE_W-1:0] code_c;

  // Stage S1: sample the sequencer requests every cycle.
  always_ff @(posedge CK or negedge CLR) begin
    if (!CLR) begin
      s1_h1 <= '0;
      s1_h2 <= '0;
    end else begin
      s1_h1 <= '{g: GRN1, y: YLW1, r: RED1};
      s1_h2 <= '{g: GRN2, y: YLW2, r: RED2};
    end
  end

  assign run_c = (state == ST_RUN);

  lamp_head_check #(
    .MIN_YLW  (MIN_YLW),
    .MAX_DARK (MAX_DARK)
  ) u_head1 (
    .clk    (CK),
    .rst_n  (CLR),
    .en     (run_c),
    .s1     (s1_h1),
    .code_c (code_h1_c)
  );

  lamp_head_check #(
    .MIN_YLW  (MIN_YLW),
    .MAX_DARK (MAX_DARK)
  ) u_head2 (
    .clk    (CK),
    .rst_n  (CLR),
    .en     (run_c),
    .s1     (s1_h2),
    .code_c (code_h2_c)
  );

  // Green or yellow on both heads at once grants right of way twice.
  assign conflict_c = (s1_h1.g | s1_h1.y) & (s1_h2.g | s1_h2.y);

  // Priority resolution: the lowest non-zero code wins.
  always_comb begin
    code_c = NONE;
    if (run_c) begin
      if (conflict_c) begin
        code_c = CONFLICT;
      end else if ((code_h1_c != NONE) &&
                   ((code_h2_c == NONE) || (code_h1_c <= code_h2_c))) begin
        code_c = code_h1_c;
      end else begin
        code_c = code_h2_c;
      end
    end
  end

  // Monitor FSM with registered drives and status.
  always_ff @(posedge CK or negedge CLR) begin
    if (!CLR) begin
      state      <= ST_ALLRED;
      ar_cnt     <= '0;
      fl_cnt     <= '0;
      drv_h1     <= RED_ON;
      drv_h2     <= RED_ON;
      FAULT      <= 1'b0;
      FAULT_CODE <= NONE;
      FLASH      <= 1'b0;
    end else begin
      case (state)
        ST_ALLRED: begin
          drv_h1 <= RED_ON;
          drv_h2 <= RED_ON;
          if (ar_cnt == AW'(ALLRED_CYC - 1)) begin
            state  <= ST_RUN;
            ar_cnt <= '0;
          end else begin
            ar_cnt <= ar_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          // A faulty sample is replaced by red-on at the same edge.
          if (code_c != NONE) begin
            state      <= ST_FLASH;
            fl_cnt     <= '0;
            drv_h1     <= RED_ON;
            drv_h2     <= RED_ON;
            FAULT      <= 1'b1;
            FAULT_CODE <= code_c;
            FLASH      <= 1'b1;
          end else begin
            drv_h1 <= s1_h1;
            drv_h2 <= s1_h2;
          end
        end

        ST_FLASH: begin
          if (ACK) begin
            state      <= ST_ALLRED;
            ar_cnt     <= '0;
            fl_cnt     <= '0;
            drv_h1     <= RED_ON;
            drv_h2     <= RED_ON;
            FAULT      <= 1'b0;
            FAULT_CODE <= NONE;
            FLASH      <= 1'b0;
          end else if (fl_cnt == FW'(FLASH_HALF - 1)) begin
            // End of a half period: both reds change phase together.
            fl_cnt <= '0;
            drv_h1 <= drv_h1.r ? ALL_OFF : RED_ON;
            drv_h2 <= drv_h1.r ? ALL_OFF : RED_ON;
          end else begin
            fl_cnt <= fl_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_ALLRED;
        end
      endcase
    end
  end

  assign L_GRN1 = drv_h1.g;
  assign L_YLW1 = drv_h1.y;
  assign L_RED1 = drv_h1.r;
  assign L_GRN2 = drv_h2.g;
  assign L_YLW2 = drv_h2.y;
  assign L_RED2 = drv_h2.r;

endmodule

// File: tb/tb_lamp_safety_monitor.sv
// Bench for lamp_safety_monitor. A reference model keeps the sample history
// since the last entry to pass-through and derives faults from run lengths
// over that history; each scenario task compares the DUT against it.
module tb_lamp_safety_monitor;

  localparam int MIN_YLW    = 3;
  localparam int MAX_DARK   = 1;
  localparam int FLASH_HALF = 4;
  localparam int ALLRED_CYC = 8;

  // {g1,y1,r1,g2,y2,r2}
  localparam logic [5:0] R1R2 = 6'b001_001;
  localparam logic [5:0] G1R2 = 6'b100_001;
  localparam logic [5:0] Y1R2 = 6'b010_001;
  localparam logic [5:0] R1G2 = 6'b001_100;
  localparam logic [5:0] R1Y2 = 6'b001_010;
  localparam logic [5:0] D1R2 = 6'b000_001;
  localparam logic [10:0] RST_OUT = 11'b001001_0_000_0;

  logic CK = 1'b0;
  logic CLR = 1'b0;
  logic GRN1 = 1'b0, YLW1 = 1'b0, RED1 = 1'b0;
  logic GRN2 = 1'b0, YLW2 = 1'b0, RED2 = 1'b0;
  logic ACK = 1'b0;
  logic L_GRN1, L_YLW1, L_RED1, L_GRN2, L_YLW2, L_RED2;
  logic FAULT, FLASH;
  logic [2:0] FAULT_CODE;

  lamp_safety_monitor dut (
    .CK(CK), .CLR(CLR),
    .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1),
    .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2),
    .ACK(ACK),
    .L_GRN1(L_GRN1), .L_YLW1(L_YLW1), .L_RED1(L_RED1),
    .L_GRN2(L_GRN2), .L_YLW2(L_YLW2), .L_RED2(L_RED2),
    .FAULT(FAULT), .FAULT_CODE(FAULT_CODE), .FLASH(FLASH)
  );

  always #5 CK = ~CK;

  wire [10:0] obs = {L_GRN1, L_YLW1, L_RED1, L_GRN2, L_YLW2, L_RED2,
                     FAULT, FAULT_CODE, FLASH};

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  int          m_mode;   // 0 all-red hold, 1 pass-through, 2 flashing
  int          m_edges;  // edges since entering the current mode
  logic [5:0]  m_s1;     // sample that the next edge acts on
  logic [5:0]  hist[$];  // accepted samples since entering pass-through
  logic [5:0]  m_drv;
  logic        m_fault;
  logic [2:0]  m_code;

  function automatic logic [10:0] exp_now();
    return {m_drv, m_fault, m_code, (m_mode == 2)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_edges = 0; m_s1 = '0; hist.delete();
    m_drv = R1R2; m_fault = 1'b0; m_code = 3'd0;
  endtask

  function automatic logic [2:0] hd(input logic [5:0] v, input int h);
    return (h == 1) ? v[5:3] : v[2:0];
  endfunction

  function automatic int trail_dark(input int h);
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hd(hist[i], h) == 3'b000) n++;
      else break;
    end
    return n;
  endfunction

  function automatic int trail_ylw(input int h);
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hd(hist[i], h) & 3'b010) n++;
      else break;
    end
    return n;
  endfunction

  // cur/prev are {g,y,r} for one head.
  function automatic int head_code(input logic [2:0] cur, input logic [2:0] prev,
                                   input int dark_prev, input int ylw_prev);
    if ($countones(cur) > 1) return 2;
    if ((cur == 3'b000) && (dark_prev + 1 > MAX_DARK)) return 3;
    if (prev[1] && !cur[1] && (ylw_prev < MIN_YLW)) return 4;
    if (prev[2] && cur[0] && !cur[2]) return 5;
    return 0;
  endfunction

  function automatic int model_check(input logic [5:0] cur);
    logic [5:0] prev;
    int c1, c2;
    prev = (hist.size() > 0) ? hist[hist.size() - 1] : 6'b0;
    if ((cur[5] | cur[4]) && (cur[2] | cur[1])) return 1;
    c1 = head_code(cur[5:3], prev[5:3], trail_dark(1), trail_ylw(1));
    c2 = head_code(cur[2:0], prev[2:0], trail_dark(2), trail_ylw(2));
    if (c1 == 0) return c2;
    if (c2 == 0) return c1;
    return (c1 < c2) ? c1 : c2;
  endfunction

  task automatic model_edge(input logic [5:0] newin, input bit ack);
    int c;
    case (m_mode)
      0: begin
        m_drv = R1R2;
        m_edges++;
        if (m_edges == ALLRED_CYC) begin
          m_mode = 1;
          hist.delete();
        end
      end
      1: begin
        c = model_check(m_s1);
        if (c != 0) begin
          m_mode = 2; m_edges = 0; m_fault = 1'b1; m_code = 3'(c); m_drv = R1R2;
        end else begin
          m_drv = m_s1;
          hist.push_back(m_s1);
          if (hist.size() > 32) void'(hist.pop_front());
        end
      end
      default: begin
        if (ack) begin
          m_mode = 0; m_edges = 0; m_fault = 1'b0; m_code = 3'd0; m_drv = R1R2;
        end else begin
          m_edges++;
          m_drv = (((m_edges / FLASH_HALF) % 2) == 0) ? R1R2 : 6'b000_000;
        end
      end
    endcase
    m_s1 = newin;
  endtask

  // Starts and ends at a falling edge; DUT outputs are settled on return.
  task automatic tick(input logic [5:0] vec, input bit ack);
    {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = vec;
    ACK = ack;
    @(posedge CK);
    #1;
    model_edge(vec, ack);
    @(negedge CK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    CLR = 1'b0;
    repeat (2) @(negedge CK);
    model_reset();
    n_vec++;
    if (obs !== RST_OUT) begin
      n_bad++; $display("FAIL reset_value: got %b want %b", obs, RST_OUT);
    end
    CLR = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick(R1R2, 1'b0);
      n_vec++;
      if (obs !== exp_now()) begin
        n_bad++; $display("FAIL reset_release[%0d]: got %b want %b", i, obs, exp_now());
      end
    end
  endtask

  task automatic test_legal_cycle();
    logic [5:0] seq[$];
    logic [5:0] prev;
    for (int i = 0; i < 10; i++) seq.push_back(G1R2);
    for (int i = 0; i < 3; i++)  seq.push_back(Y1R2);
    for (int i = 0; i < 4; i++)  seq.push_back(R1R2);
    for (int i = 0; i < 10; i++) seq.push_back(R1G2);
    for (int i = 0; i < 3; i++)  seq.push_back(R1Y2);
    for (int i = 0; i < 4; i++)  seq.push_back(R1R2);
    prev = R1R2;
    foreach (seq[i]) begin
      tick(seq[i], 1'b0);
      n_vec++;
      if (obs !== exp_now()) begin
        n_bad++; $display("FAIL legal_cycle[%0d]: got %b want %b", i, obs, exp_now());
      end
      // Drives lag the request by two edges: they show the previous vector.
      n_vec++;
      if (obs !== {prev, 5'b0}) begin
        n_bad++; $display("FAIL legal_passthru[%0d]: got %b want %b", i, obs, {prev, 5'b0});
      end
      prev = seq[i];
    end
  endtask

  task automatic test_conflict();
    tick(6'b100_100, 1'b0);
    n_vec++;
    if (FAULT !== 1'b0) begin
      n_bad++; $display("FAIL conflict_early: got %b want 0", FAULT);
    end
    for (int i = 0; i < 20; i++) begin
      tick(R1R2, 1'b0);
      n_vec++;
      if (obs !== exp_now() || (L_GRN1 & L_GRN2)) begin
        n_bad++; $display("FAIL conflict_flash[%0d]: got %b want %b", i, obs, exp_now());
      end
      // Red phase from entry: on for 4 edges, off for 4.
      n_vec++;
      if ({FAULT, FAULT_CODE, L_RED1, L_RED2} !== {1'b1, 3'd1, {2{((i / 4) % 2) == 0}}}) begin
        n_bad++;
        $display("FAIL conflict_blink[%0d]: got %b want %b", i,
                 {FAULT, FAULT_CODE, L_RED1, L_RED2}, {1'b1, 3'd1, {2{((i / 4) % 2) == 0}}});
      end
    end
    for (int i = 0; i < ALLRED_CYC + 2; i++) begin
      tick(R1R2, i == 0);
      n_vec++;
      if (obs !== exp_now()) begin
        n_bad++; $display("FAIL conflict_ack[%0d]: got %b want %b", i, obs, exp_now());
      end
    end
  endtask

  task automatic test_short_skip();
    logic [5:0] seq_a[$] = '{G1R2, G1R2, G1R2, Y1R2, Y1R2, R1R2, R1R2};
    logic [5:0] seq_b[$] = '{G1R2, G1R2, G1R2, R1R2, R1R2};
    foreach (seq_a[i]) begin
      tick(seq_a[i], 1'b0);
      n_vec++;
      if (obs !== exp_now()) begin
        n_bad++; $display("FAIL short_ylw[%0d]: got %b want %b", i, obs, exp_now());
      end
    end
    n_vec++;
    if (FAULT_CODE !== 3'd4) begin
      n_bad++; $display("FAIL short_ylw_code: got %0d want 4", FAULT_CODE);
    end
    for (int i = 0; i < ALLRED_CYC + 2; i++) begin
      tick(R1R2, i == 0);
      n_vec++;
      if (obs !== exp_now()) begin
        n_bad++; $display("FAIL short_ack[%0d]: got %b want %b", i, obs, exp_now());
      end
    end
    foreach (seq_b[i]) begin
      tick(seq_b[i], 1'b0);
      n_vec++;
      if (obs !== exp_now()) begin
        n_bad++; $display("FAIL skip_ylw[%0d]: got %b want %b", i, obs, exp_now());
      end
    end
    n_vec++;
    if (FAULT_CODE !== 3'd5) begin
      n_bad++; $display("FAIL skip_ylw_code: got %0d want 5", FAULT_CODE);
    end
    for (int i = 0; i < ALLRED_CYC + 2; i++) begin
      tick(R1R2, i == 0);
      n_vec++;
      if (obs !== exp_now()) begin
        n_bad++; $display("FAIL skip_ack[%0d]: got %b want %b", i, obs, exp_now());
      end
    end
  endtask

  task automatic test_dark_multi();
    logic [5:0] seq_a[$] = '{D1R2, R1R2, R1R2, D1R2, D1R2, R1R2};
    foreach (seq_a[i]) begin
      tick(seq_a[i], 1'b0);
      n_vec++;
      if (obs !== exp_now()) begin
        n_bad++; $display("FAIL dark[%0d]: got %b want %b", i, obs, exp_now());
      end
      // One dark cycle is tolerated; the second consecutive one faults.
      if (i == 3) begin
        n_vec++;
        if (FAULT !== 1'b0) begin
          n_bad++; $display("FAIL dark_one_ok: got %b want 0", FAULT);
        end
      end
    end
    n_vec++;
    if (FAULT_CODE !== 3'd3) begin
      n_bad++; $display("FAIL dark_code: got %0d want 3", FAULT_CODE);
    end
    for (int i = 0; i < ALLRED_CYC + 2; i++) begin
      tick(R1R2, i == 0);
      n_vec++;
      if (obs !== exp_now()) begin
        n_bad++; $display("FAIL dark_ack[%0d]: got %b want %b", i, obs, exp_now());
      end
    end
    tick(6'b110_100, 1'b0);
    tick(R1R2, 1'b0);
    n_vec++;
    if ({FAULT, FAULT_CODE} !== {1'b1, 3'd1} || obs !== exp_now()) begin
      n_bad++; $display("FAIL conflict_over_multi: got %b want %b", obs, exp_now());
    end
    for (int i = 0; i < ALLRED_CYC + 2; i++) begin
      tick(R1R2, i == 0);
      n_vec++;
      if (obs !== exp_now()) begin
        n_bad++; $display("FAIL multi_ack[%0d]: got %b want %b", i, obs, exp_now());
      end
    end
  endtask

  task automatic test_ack_in_run();
    for (int i = 0; i < 6; i++) begin
      tick(R1R2, 1'b1);
      n_vec++;
      if (obs !== exp_now() || FAULT !== 1'b0 || FLASH !== 1'b0) begin
        n_bad++; $display("FAIL ack_in_run[%0d]: got %b want %b", i, obs, exp_now());
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] legal[5] = '{R1R2, G1R2, Y1R2, R1G2, R1Y2};
    logic [5:0] vec = R1R2;
    bit ack;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    vec = legal[$urandom_range(0, 4)];
        2:       vec = 6'($urandom);
        default: ;
      endcase
      ack = ($urandom_range(0, 5) == 0);
      tick(vec, ack);
      n_vec++;
      if (obs !== exp_now()) begin
        n_bad++; $display("FAIL random[%0d]: got %b want %b", i, obs, exp_now());
      end
    end
    for (int i = 0; i < ALLRED_CYC + 2; i++) begin
      tick(R1R2, 1'b1);
      n_vec++;
      if (obs !== exp_now()) begin
        n_bad++; $display("FAIL random_drain[%0d]: got %b want %b", i, obs, exp_now());
      end
    end
  endtask

  task automatic test_clr_midflash();
    tick(6'b010_010, 1'b0);
    for (int i = 0; i < 5; i++) tick(R1R2, 1'b0);
    n_vec++;
    if (FLASH !== 1'b1 || FAULT_CODE !== 3'd1) begin
      n_bad++; $display("FAIL clr_pre_flash: got %b want FLASH with code 1", obs);
    end
    #2 CLR = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (obs !== RST_OUT) begin
      n_bad++; $display("FAIL clr_async: got %b want %b", obs, RST_OUT);
    end
    @(negedge CK);
    CLR = 1'b1;
    for (int i = 0; i < ALLRED_CYC + 4; i++) begin
      tick(R1R2, 1'b0);
      n_vec++;
      if (obs !== exp_now()) begin
        n_bad++; $display("FAIL clr_recover[%0d]: got %b want %b", i, obs, exp_now());
      end
    end
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_conflict();
    test_short_skip();
    test_dark_multi();
    test_ack_in_run();
    test_random();
    test_clr_midflash();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
